fifo_rd_packer: RTL

FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

---
 rtl/fifo_rd_packer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: reads IN_WIDTH words from a first-word-fall-through-less FIFO
// (data one cycle after the read strobe) and packs RATIO of them into one
// OUT_WIDTH output word, lane 0 first. Partial words are emitted on flush.
// Optional idle-timeout flush is enabled by defining PACKER_TIMEOUT_FLUSH_EN.
module fifo_rd_packer #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4,
  parameter int TIMEOUT  = 16,
  localparam int OUT_WIDTH = IN_WIDTH * RATIO
) (
  input  logic                 rd_clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  input  logic [IN_WIDTH-1:0]  fifo_dout,
  output logic                 fifo_rd_en,
  input  logic                 flush,
  output logic [OUT_WIDTH-1:0] m_data,
  output logic [RATIO-1:0]     m_keep,
  output logic                 m_last,
  output logic                 m_valid,
  input  logic                 m_ready
);

  localparam int CW = $clog2(RATIO) + 1;
  localparam logic [CW-1:0] RATIO_C = CW'(RATIO);

  typedef enum logic {FILL = 1'b0, FLUSH = 1'b1} state_t;

  state_t               state_reg, state_next;
  logic [CW-1:0]        cnt_reg;
  logic                 inflight_reg;
  logic [OUT_WIDTH-1:0] acc_reg;
  logic [OUT_WIDTH-1:0] acc_merged;
  logic [RATIO-1:0]     keep_part;
  logic [CW-1:0]        cnt_sum;
  logic                 slot_free;
  logic                 pending;
  logic                 timeout_hit;
  logic                 trigger;
  logic                 load_full;
  logic                 load_flush;

  // Lanes that will be held once any in-flight word lands this cycle.
  assign cnt_sum   = cnt_reg + CW'(inflight_reg);
  assign slot_free = !m_valid || m_ready;
  assign pending   = (cnt_reg != '0) || inflight_reg;
  assign trigger   = flush || timeout_hit;

  assign fifo_rd_en = !fifo_empty && !rst && (state_reg == FILL) && (cnt_sum < RATIO_C);

  // The landing word is merged into the accumulator view so a full word can be
  // emitted on the same edge its last lane arrives (one bubble per word).
  for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
    assign acc_merged[gi*IN_WIDTH +: IN_WIDTH] =
      (inflight_reg && (cnt_reg == CW'(gi))) ? fifo_dout : acc_reg[gi*IN_WIDTH +: IN_WIDTH];
    assign keep_part[gi] = (CW'(gi) < cnt_reg);
  end

`ifdef PACKER_TIMEOUT_FLUSH_EN
  logic [7:0] idle_reg;
  logic       idle_cond;

  assign idle_cond   = (state_reg == FILL) && (cnt_reg != '0) && !inflight_reg && fifo_empty;
  assign timeout_hit = idle_cond && (idle_reg == 8'(TIMEOUT));

  // Idle counter: counts starved cycles with a partial word held, saturating at TIMEOUT.
  always_ff @(posedge rd_clk) begin
    if (rst || !idle_cond) begin
      idle_reg <= 8'd0;
    end else if (idle_reg != 8'(TIMEOUT)) begin
      idle_reg <= idle_reg + 8'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and load decisions; a flush request outranks a normal full load
  // so a full word caught by flush leaves with m_last set.
  always_comb begin
    state_next = state_reg;
    load_full  = 1'b0;
    load_flush = 1'b0;
    case (state_reg)
      FILL: begin
        if (trigger && pending) begin
          state_next = FLUSH;
        end else if ((cnt_sum == RATIO_C) && slot_free) begin
          load_full = 1'b1;
        end
      end
      FLUSH: begin
        if (!inflight_reg && slot_free) begin
          load_flush = 1'b1;
          state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  // State, lane accumulation and output register.
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      state_reg    <= FILL;
      cnt_reg      <= '0;
      inflight_reg <= 1'b0;
      acc_reg      <= '0;
      m_data       <= '0;
      m_keep       <= '0;
      m_last       <= 1'b0;
      m_valid      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= fifo_rd_en;
      if (load_full || load_flush) begin
        // Clearing the accumulator keeps unused lanes of later partial words zero.
        m_data  <= acc_merged;
        m_keep  <= load_full ? {RATIO{1'b1}} : keep_part;
        m_last  <= load_flush;
        m_valid <= 1'b1;
        cnt_reg <= '0;
        acc_reg <= '0;
      end else begin
        if (inflight_reg) begin
          acc_reg <= acc_merged;
          cnt_reg <= cnt_reg + CW'(1);
        end
        if (m_valid && m_ready) begin
          m_valid <= 1'b0;
        end
      end
    end
  end

endmodule
